// File: rtl/rbz_bridge_pkg.sv
// Shared definitions for the Wishbone-to-register-SPI bridge.
// Holds the register window byte offsets, CTRL/STATUS bit positions,
// the transmit FSM state type and the LEN clamping helper.
package rbz_bridge_pkg;

  localparam int unsigned OFS_DATA   = 32'h0;
  localparam int unsigned OFS_CTRL   = 32'h4;
  localparam int unsigned OFS_STATUS = 32'h8;

  localparam int CTRL_START_BIT  = 8;
  localparam int CTRL_IRQ_EN_BIT = 9;

  localparam int STATUS_BUSY_BIT    = 0;
  localparam int STATUS_DONE_BIT    = 1;
  localparam int STATUS_OVERRUN_BIT = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_TAIL,
    ST_GAP
  } spi_state_t;

  // A 6-bit LEN field can hold up to 63; anything above 32 means "full word".
  function automatic logic [5:0] clamp_len(input logic [5:0] raw);
    return (raw > 6'd32) ? 6'd32 : raw;
  endfunction

endpackage

// File: rtl/spi_shift_tx.sv
// Mode-0 SPI transmitter for one 1..32-bit frame, MSB first.
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   start          one-cycle request; sampled only while idle
//   data, len      payload (right-aligned) and bit count 1..32
//   busy           high from the first LO state through the end of GAP
//   done           one-cycle pulse on the edge that returns to IDLE
//   csb, sclk, mosi registered SPI pins
module spi_shift_tx
  import rbz_bridge_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] data,
  input  logic [5:0]  len,
  output logic        busy,
  output logic        done,
  output logic        csb,
  output logic        sclk,
  output logic        mosi
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  spi_state_t       state, state_n;
  logic [DIV_W-1:0] div_cnt, div_n;
  logic [5:0]       bit_cnt, bit_n;
  logic [31:0]      shreg, shreg_n;
  logic             half_end;
  logic             frame_n;
  logic             csb_n, sclk_n, mosi_n;

  assign half_end = (div_cnt == DIV_LAST);
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_GAP) && half_end;

  // State, counters and pins all update on the same edge, so the pins are
  // glitch-free registers that line up exactly with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      csb     <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else begin
      state   <= state_n;
      div_cnt <= div_n;
      bit_cnt <= bit_n;
      shreg   <= shreg_n;
      csb     <= csb_n;
      sclk    <= sclk_n;
      mosi    <= mosi_n;
    end
  end

  // Every non-idle state lasts CLK_DIV cycles. The payload is left-aligned at
  // load time so the current bit is always shreg[31]; the last bit is not
  // shifted out so TAIL keeps driving it.
  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    div_n   = (state == ST_IDLE || half_end) ? '0 : div_cnt + DIV_W'(1);
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_LO;
          shreg_n = data << (6'd32 - len);
          bit_n   = len;
        end
      end
      ST_LO: begin
        if (half_end) state_n = ST_HI;
      end
      ST_HI: begin
        if (half_end) begin
          bit_n = bit_cnt - 6'd1;
          if (bit_cnt == 6'd1) begin
            state_n = ST_TAIL;
          end else begin
            shreg_n = shreg << 1;
            state_n = ST_LO;
          end
        end
      end
      ST_TAIL: begin
        if (half_end) state_n = ST_GAP;
      end
      ST_GAP: begin
        if (half_end) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    frame_n = (state_n == ST_LO) || (state_n == ST_HI) || (state_n == ST_TAIL);
    csb_n   = !frame_n;
    sclk_n  = (state_n == ST_HI);
    mosi_n  = frame_n ? shreg_n[31] : 1'b0;
  end

endmodule

// File: rtl/wb_reg_spi_bridge.sv
// Wishbone classic slave that turns single register writes into raybox
// register-SPI frames, replacing LA bit-banging of csb/sclk/mosi.
// Ports:
//   i_clk, i_reset            system clock, synchronous active-high reset
//   i_wb_*                    Wishbone classic slave request
//   o_wb_ack, o_wb_dat        one-cycle ack with registered read data
//   o_reg_csb/sclk/mosi       SPI pins toward the register port mux
//   o_irq                     level interrupt, done & irq_en
// Window: DATA at +0x0, CTRL at +0x4 (LEN, START, irq_en), STATUS at +0x8.
module wb_reg_spi_bridge
  import rbz_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          ADDR_BITS = 4,
  parameter int          CLK_DIV   = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [3:0]  i_wb_sel,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_dat,
  output logic        o_reg_csb,
  output logic        o_reg_sclk,
  output logic        o_reg_mosi,
  output logic        o_irq
);

  logic [ADDR_BITS-1:0] ofs;
  logic                 hit, accept, wr;
  logic                 is_data, is_ctrl, is_status;
  logic [5:0]           new_len, eff_len;
  logic                 start_req;
  logic [31:0]          rd_val;

  logic [31:0] data_q;
  logic [5:0]  len_q;
  logic        irq_en_q, done_q, overrun_q, start_q;
  logic        busy, tx_done;

  assign ofs       = i_wb_adr[ADDR_BITS-1:0];
  assign hit       = i_wb_cyc && i_wb_stb &&
                     (i_wb_adr[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]);
  // Blocking accepts during the ack cycle keeps a held request from being
  // executed twice.
  assign accept    = hit && !o_wb_ack;
  assign wr        = accept && i_wb_we;
  assign is_data   = (ofs == ADDR_BITS'(OFS_DATA));
  assign is_ctrl   = (ofs == ADDR_BITS'(OFS_CTRL));
  assign is_status = (ofs == ADDR_BITS'(OFS_STATUS));
  assign new_len   = clamp_len(i_wb_dat[5:0]);
  assign eff_len   = i_wb_sel[0] ? new_len : len_q;
  assign start_req = wr && is_ctrl && i_wb_sel[1] && i_wb_dat[CTRL_START_BIT];
  assign o_irq     = done_q && irq_en_q;

  // Read mux; unmapped offsets return zero.
  always_comb begin
    rd_val = '0;
    if (is_data) begin
      rd_val = data_q;
    end else if (is_ctrl) begin
      rd_val[5:0]             = len_q;
      rd_val[CTRL_IRQ_EN_BIT] = irq_en_q;
    end else if (is_status) begin
      rd_val[STATUS_BUSY_BIT]    = busy;
      rd_val[STATUS_DONE_BIT]    = done_q;
      rd_val[STATUS_OVERRUN_BIT] = overrun_q;
    end
  end

  // Bus handshake and register file. START is registered so the transmitter
  // sees the freshly written DATA/LEN; statements are ordered so a set from
  // the transmitter beats a same-cycle write-one-to-clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_wb_ack  <= 1'b0;
      o_wb_dat  <= '0;
      data_q    <= '0;
      len_q     <= '0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      o_wb_ack <= accept;
      o_wb_dat <= (accept && !i_wb_we) ? rd_val : 32'd0;
      start_q  <= 1'b0;

      if (wr && is_status && i_wb_sel[0]) begin
        if (i_wb_dat[STATUS_DONE_BIT])    done_q    <= 1'b0;
        if (i_wb_dat[STATUS_OVERRUN_BIT]) overrun_q <= 1'b0;
      end

      if (wr && is_data) begin
        if (busy) begin
          overrun_q <= 1'b1;
        end else begin
          for (int b = 0; b < 4; b++)
            if (i_wb_sel[b]) data_q[8*b +: 8] <= i_wb_dat[8*b +: 8];
        end
      end

      if (wr && is_ctrl) begin
        if (i_wb_sel[0]) len_q    <= new_len;
        if (i_wb_sel[1]) irq_en_q <= i_wb_dat[CTRL_IRQ_EN_BIT];
      end

      if (start_req) begin
        if (busy) begin
          overrun_q <= 1'b1;
        end else if (eff_len != 6'd0) begin
          start_q <= 1'b1;
          done_q  <= 1'b0;
        end
      end

      if (tx_done) done_q <= 1'b1;
    end
  end

  spi_shift_tx #(
    .CLK_DIV(CLK_DIV)
  ) u_tx (
    .clk  (i_clk),
    .reset(i_reset),
    .start(start_q),
    .data (data_q),
    .len  (len_q),
    .busy (busy),
    .done (tx_done),
    .csb  (o_reg_csb),
    .sclk (o_reg_sclk),
    .mosi (o_reg_mosi)
  );

endmodule

// File: tb/tb_wb_reg_spi_bridge.sv
// Directed bench for wb_reg_spi_bridge: bus access, frame shape, status,
// IRQ, overrun, bus corner cases and back-to-back frames.
module tb_wb_reg_spi_bridge;

  localparam logic [31:0] A_DATA = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = 32'h3000_0004;
  localparam logic [31:0] A_STAT = 32'h3000_0008;
  localparam logic [31:0] A_RSV  = 32'h3000_000C;
  localparam logic [31:0] A_MISS = 32'h3000_0010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack, csb, sclk, mosi, irq;
  logic [31:0] rdat;

  int errors = 0;
  int checks = 0;

  // Monitor state: only ever written here; tests work with snapshots.
  int          rx_bits = 0;
  logic [31:0] rx_word = '0;
  int          frames = 0;
  int          csb_low = 0;
  int          high_run = 0;
  int          last_gap = 0;

  always #5 clk = ~clk;

  wb_reg_spi_bridge #(
    .BASE_ADDR(32'h3000_0000),
    .ADDR_BITS(4),
    .CLK_DIV  (2)
  ) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_wb_cyc  (cyc),
    .i_wb_stb  (stb),
    .i_wb_we   (we),
    .i_wb_sel  (sel),
    .i_wb_adr  (adr),
    .i_wb_dat  (wdat),
    .o_wb_ack  (ack),
    .o_wb_dat  (rdat),
    .o_reg_csb (csb),
    .o_reg_sclk(sclk),
    .o_reg_mosi(mosi),
    .o_irq     (irq)
  );

  // What the target would sample on each rising sclk.
  always @(posedge sclk) begin
    rx_word <= {rx_word[30:0], mosi};
    rx_bits <= rx_bits + 1;
  end

  always @(negedge csb) frames <= frames + 1;

  // Cycles with csb low, and the length of the high gap before each frame.
  always @(posedge clk) begin
    if (csb === 1'b0) begin
      csb_low <= csb_low + 1;
      if (high_run != 0) last_gap <= high_run;
      high_run <= 0;
    end else begin
      high_run <= high_run + 1;
    end
  end

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] r, output logic acked);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    acked = 1'b0;
    r = '0;
    for (int i = 0; i < 8 && !acked; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        acked = 1'b1;
        r = rdat;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic acked);
    logic [31:0] unused_r;
    wb_xfer(1'b1, a, d, s, unused_r, acked);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] r, output logic acked);
    wb_xfer(1'b0, a, 32'h0, 4'hF, r, acked);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    logic a;
    reset = 1'b1;
    wait_cycles(3);
    checks++;
    if ({csb, sclk, mosi, ack, irq} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL reset_pins: got csb,sclk,mosi,ack,irq=%b expected 10000",
               {csb, sclk, mosi, ack, irq});
    end
    checks++;
    if (rdat !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_rdat: got %h expected 00000000", rdat);
    end
    @(negedge clk) reset = 1'b0;
    wb_read(A_STAT, r, a);
    checks++;
    if (!a || r !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_status: got ack=%b data=%h expected ack=1 data=00000000", a, r);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] r;
    logic a;
    wb_write(A_DATA, 32'h0000_00A5, 4'hF, a);
    wb_write(A_CTRL, 32'h0000_0308, 4'hF, a);
    wait_cycles(12);
    checks++;
    if (csb !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_in_frame: got csb=%b expected 0", csb);
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({csb, sclk} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL midreset_pins: got csb,sclk=%b expected 10", {csb, sclk});
    end
    wait_cycles(2);
    @(negedge clk) reset = 1'b0;
    wait_cycles(60);
    wb_read(A_STAT, r, a);
    checks++;
    if (r !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_status: got status=%h irq=%b expected 00000000 irq=0", r, irq);
    end
    wb_read(A_DATA, r, a);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_data: got %h expected 00000000", r);
    end
  endtask

  task automatic test_basic_frame();
    logic [31:0] r;
    logic a;
    int b0, l0, f0;
    wb_write(A_DATA, 32'h0000_00A5, 4'hF, a);
    checks++;
    if (a !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_data_ack: got %b expected 1", a);
    end
    b0 = rx_bits; l0 = csb_low; f0 = frames;
    wb_write(A_CTRL, 32'h0000_0108, 4'hF, a);
    checks++;
    if (csb !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_csb_ack_cycle: got %b expected 1", csb);
    end
    @(posedge clk); #1;
    checks++;
    if (csb !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_csb_fall: got %b expected 0", csb);
    end
    wb_read(A_STAT, r, a);
    checks++;
    if (r !== 32'h1) begin
      errors++;
      $display("[TB] FAIL basic_busy: got %h expected 00000001", r);
    end
    wait_cycles(60);
    checks++;
    if (rx_bits - b0 != 8 || rx_word[7:0] !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL basic_bits: got %0d bits %h expected 8 bits a5", rx_bits - b0, rx_word[7:0]);
    end
    checks++;
    if (csb_low - l0 != 34 || frames - f0 != 1) begin
      errors++;
      $display("[TB] FAIL basic_csb_len: got %0d cycles %0d frames expected 34 cycles 1 frame",
               csb_low - l0, frames - f0);
    end
    wb_read(A_STAT, r, a);
    checks++;
    if (r !== 32'h2) begin
      errors++;
      $display("[TB] FAIL basic_done: got %h expected 00000002", r);
    end
  endtask

  task automatic test_full_width_irq();
    logic [31:0] r;
    logic a;
    int b0, l0;
    wb_write(A_DATA, 32'h8000_0001, 4'hF, a);
    b0 = rx_bits; l0 = csb_low;
    wb_write(A_CTRL, 32'h0000_0320, 4'hF, a);
    wait_cycles(10);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_irq_during: got %b expected 0", irq);
    end
    wait_cycles(150);
    checks++;
    if (rx_bits - b0 != 32 || rx_word !== 32'h8000_0001) begin
      errors++;
      $display("[TB] FAIL full_bits: got %0d bits %h expected 32 bits 80000001", rx_bits - b0, rx_word);
    end
    checks++;
    if (csb_low - l0 != 130) begin
      errors++;
      $display("[TB] FAIL full_csb_len: got %0d expected 130", csb_low - l0);
    end
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_irq_done: got %b expected 1", irq);
    end
    wb_write(A_STAT, 32'h0000_0002, 4'hF, a);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_irq_clear: got %b expected 0", irq);
    end
    wb_read(A_STAT, r, a);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("[TB] FAIL full_status_clear: got %h expected 00000000", r);
    end
  endtask

  task automatic test_overrun();
    logic [31:0] r;
    logic a;
    int b0, f0;
    wb_write(A_DATA, 32'h0000_003C, 4'hF, a);
    b0 = rx_bits; f0 = frames;
    wb_write(A_CTRL, 32'h0000_0108, 4'hF, a);
    wb_write(A_DATA, 32'hFFFF_FFFF, 4'hF, a);
    wb_write(A_CTRL, 32'h0000_0108, 4'hF, a);
    wait_cycles(80);
    checks++;
    if (rx_bits - b0 != 8 || rx_word[7:0] !== 8'h3C || frames - f0 != 1) begin
      errors++;
      $display("[TB] FAIL overrun_frame: got %0d bits %h %0d frames expected 8 bits 3c 1 frame",
               rx_bits - b0, rx_word[7:0], frames - f0);
    end
    wb_read(A_DATA, r, a);
    checks++;
    if (r !== 32'h0000_003C) begin
      errors++;
      $display("[TB] FAIL overrun_data: got %h expected 0000003c", r);
    end
    wb_read(A_STAT, r, a);
    checks++;
    if (r !== 32'h6) begin
      errors++;
      $display("[TB] FAIL overrun_status: got %h expected 00000006", r);
    end
    wb_write(A_STAT, 32'h0000_0006, 4'hF, a);
    wb_read(A_STAT, r, a);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("[TB] FAIL overrun_w1c: got %h expected 00000000", r);
    end
  endtask

  task automatic test_bus_corners();
    logic [31:0] r;
    logic a;
    int f0;
    f0 = frames;
    wb_write(A_CTRL, 32'h0000_0100, 4'hF, a);
    wait_cycles(20);
    wb_read(A_STAT, r, a);
    checks++;
    if (r !== 32'h0 || frames - f0 != 0) begin
      errors++;
      $display("[TB] FAIL len0_start: got status=%h frames=%0d expected 00000000 frames=0",
               r, frames - f0);
    end
    wb_write(A_RSV, 32'hFFFF_FFFF, 4'hF, a);
    wb_read(A_RSV, r, a);
    checks++;
    if (a !== 1'b1 || r !== 32'h0) begin
      errors++;
      $display("[TB] FAIL rsv_read: got ack=%b data=%h expected ack=1 data=00000000", a, r);
    end
    wb_write(A_MISS, 32'h0000_DEAD, 4'hF, a);
    checks++;
    if (a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL miss_ack: got %b expected 0", a);
    end
    wb_read(A_DATA, r, a);
    checks++;
    if (r !== 32'h0000_003C) begin
      errors++;
      $display("[TB] FAIL miss_no_effect: got %h expected 0000003c", r);
    end
    wb_write(A_DATA, 32'h1122_3344, 4'hF, a);
    wb_write(A_DATA, 32'hAABB_CCDD, 4'b0001, a);
    wb_read(A_DATA, r, a);
    checks++;
    if (r !== 32'h1122_33DD) begin
      errors++;
      $display("[TB] FAIL sel_byte0: got %h expected 112233dd", r);
    end
    wb_write(A_CTRL, 32'h0000_003F, 4'hF, a);
    wb_read(A_CTRL, r, a);
    checks++;
    if (r !== 32'h0000_0020) begin
      errors++;
      $display("[TB] FAIL len_clamp: got %h expected 00000020", r);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic a;
    logic idle_seen;
    int b0, f0;
    b0 = rx_bits; f0 = frames;
    wb_write(A_CTRL, 32'h0000_0104, 4'hF, a);
    idle_seen = 1'b0;
    for (int i = 0; i < 100 && !idle_seen; i++) begin
      wb_read(A_STAT, r, a);
      if (a && r[0] == 1'b0) idle_seen = 1'b1;
    end
    checks++;
    if (idle_seen !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_poll: got busy stuck, expected busy=0 within 100 polls");
    end
    wb_write(A_CTRL, 32'h0000_0104, 4'hF, a);
    wait_cycles(40);
    checks++;
    if (frames - f0 != 2 || rx_bits - b0 != 8 || rx_word[7:0] !== 8'hDD) begin
      errors++;
      $display("[TB] FAIL b2b_frames: got %0d frames %0d bits %h expected 2 frames 8 bits dd",
               frames - f0, rx_bits - b0, rx_word[7:0]);
    end
    checks++;
    if (last_gap < 2) begin
      errors++;
      $display("[TB] FAIL b2b_gap: got %0d cycles expected at least 2", last_gap);
    end
    wb_read(A_STAT, r, a);
    checks++;
    if (r !== 32'h2) begin
      errors++;
      $display("[TB] FAIL b2b_status: got %h expected 00000002", r);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_frame();
    test_basic_frame();
    test_full_width_irq();
    test_overrun();
    test_bus_corners();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case a task never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/wb_reg_spi_bridge.md
Name: wb_reg_spi_bridge

Overview:
- Wishbone classic slave that lets the management core write raybox register frames as single bus writes, instead of bit-banging i_reg_csb/i_reg_sclk/i_reg_mosi through LA pins.
- Sits directly upstream of top_ew_algofoogle's register SPI port. Its three outputs drive that port through the wrapper-level source mux.
- Shifts a 1–32-bit payload MSB-first in SPI mode 0, then reports completion via status and IRQ.

Parameters:
- BASE_ADDR, 32'h3000_0000, Wishbone base address of the register window.
- ADDR_BITS, 4, width of the window offset; the upper 32-ADDR_BITS address bits must equal BASE_ADDR.
- CLK_DIV, 2, i_clk cycles per SCLK half-period (legal range ≥1).

Ports:
- i_clk  in  1  system clock (wb_clk_i in the wrapper)
- i_reset  in  1  synchronous, active-high reset
- i_wb_cyc  in  1  Wishbone cycle
- i_wb_stb  in  1  Wishbone strobe
- i_wb_we  in  1  write enable
- i_wb_sel  in  4  byte enables
- i_wb_adr  in  32  address
- i_wb_dat  in  32  write data
- o_wb_ack  out  1  acknowledge
- o_wb_dat  out  32  read data
- o_reg_csb  out  1  SPI chip select (active low), to i_reg_csb
- o_reg_sclk  out  1  SPI clock, to i_reg_sclk
- o_reg_mosi  out  1  SPI data, to i_reg_mosi
- o_irq  out  1  level IRQ = done & irq_en

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-high on i_reset.
- Reset values:
  - o_reg_csb=1, o_reg_sclk=0, o_reg_mosi=0, o_wb_ack=0, o_wb_dat=0, o_irq=0.
  - DATA=0, LEN=0, irq_en=0, done=0, overrun=0, FSM=IDLE.
- Reset mid-frame: on the next edge csb goes 1 and sclk goes 0; the frame is aborted and done is not set.
- Bus decode: hit = cyc & stb & (adr[31:ADDR_BITS]==BASE_ADDR[31:ADDR_BITS]).
- Bus timing:
  - o_wb_ack pulses exactly 1 cycle, registered the cycle after a hit.
  - No ack is issued while ack is already high, so a held request is acked once per 2 cycles.
  - Misses get no ack.
- Register map (byte offsets):
  - 0x0 DATA, RW:
    - Honours i_wb_sel per byte.
    - A write while busy is dropped and sets overrun.
  - 0x4 CTRL:
    - Byte0 bits[5:0] = LEN; valid 1..32, values >32 clamp to 32.
    - Byte1 bit8 = START, write-only and self-clearing.
    - Byte1 bit9 = irq_en.
    - START with LEN=0 is ignored.
    - START while busy is ignored and sets overrun.
    - A write with both LEN and START in the same access uses the new LEN.
  - 0x8 STATUS:
    - bit0 busy (RO); bit1 done (W1C); bit2 overrun (W1C).
    - START clears done.
  - 0xC and other offsets: reads return 0; writes are acked and have no effect.
- Read data: o_wb_dat is registered with the ack and is 0 when ack=0.
- FSM states: IDLE, LO, HI, TAIL, GAP. A half-period counter counts CLK_DIV cycles per state visit.
  - IDLE → LO on accepted START. Shift register loads DATA left-aligned (DATA << (32-LEN)), bit counter = LEN.
  - LO: csb=0, sclk=0, mosi = shreg[31].
  - HI: sclk=1; the target samples on the rising edge. At the end of HI, the bit counter decrements.
    - Bit counter now 0 → TAIL.
    - Otherwise shift left and → LO.
  - TAIL: csb=0, sclk=0, mosi held.
  - GAP: csb=1, mosi=0, for CLK_DIV cycles; at exit done=1 and → IDLE.
- Frame timing:
  - csb falls 1 cycle after the START ack cycle.
  - Frame length (csb low) = CLK_DIV*(2*LEN+1) cycles.
  - busy = (state != IDLE), including GAP.
- Simultaneous events:
  - A W1C of done in the same cycle that the FSM sets done: set wins.
  - A DATA write in the cycle the FSM enters IDLE is accepted (busy already 0 that cycle).

Decomposition:
- Package rbz_bridge_pkg:
  - Register offsets OFS_DATA/OFS_CTRL/OFS_STATUS.
  - CTRL/STATUS bit indices.
  - FSM state enum spi_state_t.
- Natural sub-module: spi_shift_tx (shift register, bit counter, half-period divider, FSM, SPI pins).
- wb_reg_spi_bridge keeps the bus decode, registers and IRQ.

Test Plan:
- Reset sequence:
  - Stimulus: assert i_reset 3 cycles mid-frame.
  - Required: csb=1, sclk=0 on the next edge; STATUS reads 0x0; o_irq=0.
- Basic frame:
  - Stimulus: CLK_DIV=2; write DATA=0x0000_00A5, CTRL=0x0108 (LEN=8, START).
  - Required: 8 rising sclk edges sample 1,0,1,0,0,1,0,1; csb low for exactly 34 cycles; then STATUS=0x2.
- Full width and IRQ:
  - Stimulus: LEN=32, DATA=0x8000_0001, irq_en=1.
  - Required: first bit 1, bits 2–31 are 0, last bit 1; o_irq rises with done; write STATUS=0x2 → o_irq=0.
- Overrun:
  - Stimulus: START, then during the frame write DATA=0xFFFF_FFFF and START again.
  - Required: the shifted bits are unchanged; a DATA read returns the old value; STATUS bit2=1; exactly one frame is sent.
- Bus corner cases:
  - LEN=0 START → no csb activity, no busy.
  - Read at 0xC → 0.
  - Address outside the window → no ack.
  - sel=4'b0001 DATA write changes only byte0.
- Back-to-back frames:
  - Stimulus: poll busy and issue a new START immediately on busy=0.
  - Required: csb stays high ≥ CLK_DIV cycles between frames.
